// File: rtl/video_pkg.sv
// Shared video definitions: pixel layout, unpacker state encoding and the
// default 640x480 scan geometry also used by the pixel generator.
package video_pkg;

  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;

  // Pixel coordinates are 10 bits wide, enough for 1023x1023.
  localparam int POS_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // One output beat: pixel plus its frame position sideband.
  typedef struct packed {
    pixel_t             data;
    logic               sof;
    logic               eol;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
  } pix_beat_t;

  // Unpacker states. SYNC hunts for tuser, PH0..PH2 take w0..w2 of a
  // 3-word group, EMIT3 stalls the input while the fourth pixel goes out.
  typedef logic [2:0] unpack_state_t;
  localparam unpack_state_t ST_SYNC  = 3'd0;
  localparam unpack_state_t ST_PH0   = 3'd1;
  localparam unpack_state_t ST_PH1   = 3'd2;
  localparam unpack_state_t ST_PH2   = 3'd3;
  localparam unpack_state_t ST_EMIT3 = 3'd4;

endpackage

// File: rtl/pix_out_reg.sv
// Single-entry valid/ready output register for one pixel beat. A new beat
// may be loaded in the same cycle the current one is accepted.
module pix_out_reg
  import video_pkg::*;
(
  input  logic      aclk,
  input  logic      aresetn,
  input  logic      load,
  input  pix_beat_t load_beat,
  input  logic      ready,
  output logic      valid,
  output pix_beat_t beat,
  output logic      handshake
);

  assign handshake = valid & ready;

  // Hold the beat until accepted; a load overrides the drain on a handshake cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= 1'b0;
      // NOTE: the payload is reset only because the pixel outputs must read
      // zero out of reset; it is a single register, not a storage array.
      beat  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      if (load) begin
        valid <= 1'b1;
        beat  <= load_beat;
      end else if (handshake) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_unpacker.sv
// AXI4-Stream sink that unpacks 3 x 32-bit words into 4 RGB888 pixels,
// adds SOF/EOL/x/y sideband and checks tuser/tlast/tkeep framing.
module stream_unpacker
  import video_pkg::*;
#(
  parameter int H_PIXELS  = DEF_H_PIXELS,
  parameter int V_LINES   = DEF_V_LINES,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [31:0]          in_stream_tdata,
  input  logic [3:0]           in_stream_tkeep,
  input  logic                 in_stream_tlast,
  input  logic                 in_stream_tuser,
  input  logic                 in_stream_tvalid,
  output logic                 in_stream_tready,
  output logic [23:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic [POS_W-1:0]     pix_x,
  output logic [POS_W-1:0]     pix_y,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 err_pulse
);

  localparam logic [POS_W-1:0] X_LAST   = POS_W'(H_PIXELS - 1);
  // x of P2 in the last group of a line; that group's w2 must carry tlast.
  localparam logic [POS_W-1:0] X_EOL_P2 = POS_W'(H_PIXELS - 2);
  localparam logic [POS_W-1:0] Y_LAST   = POS_W'(V_LINES - 1);

  unpack_state_t    state;
  unpack_state_t    state_nxt;
  logic             run;          // low during and one cycle after reset
  logic [7:0]       r8;
  logic [15:0]      r16;
  pixel_t           p3;
  logic [POS_W-1:0] nx;           // position of the next pixel to load
  logic [POS_W-1:0] ny;
  logic             frame_err;

  logic             out_valid;
  logic             out_hs;
  pix_beat_t        out_beat;

  logic             acc;
  logic             at_frame_start;
  logic             start;
  logic             active;
  unpack_state_t    eff_state;
  logic [POS_W-1:0] eff_x;
  logic [POS_W-1:0] eff_y;
  logic             tuser_err;
  logic             sof_miss_err;
  logic             tlast_err;
  logic             keep_err;
  logic             any_err;
  logic             discard;
  logic             load;
  pixel_t           load_pix;
  pix_beat_t        load_beat;
  logic             last_p3;

  // Input accepted only when the output register has room and P3 is not pending.
  assign in_stream_tready = run && (state != ST_EMIT3) && (!out_valid || pix_ready);
  assign acc              = in_stream_tvalid && in_stream_tready;
  assign at_frame_start   = (state == ST_PH0) && (nx == '0) && (ny == '0);

  // Classify the accepted word, run the framing checks and pick the pixel to load.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    start        = acc && in_stream_tuser;
    active       = acc && ((state != ST_SYNC) || in_stream_tuser);
    eff_state    = start ? ST_PH0 : state;
    eff_x        = start ? '0 : nx;
    eff_y        = start ? '0 : ny;
    tuser_err    = start && (state != ST_SYNC) && !at_frame_start;
    sof_miss_err = acc && !in_stream_tuser && at_frame_start;
    tlast_err    = active &&
                   (in_stream_tlast != ((eff_state == ST_PH2) && (eff_x == X_EOL_P2)));
    keep_err     = acc && (in_stream_tkeep != 4'hF);
    any_err      = tuser_err || sof_miss_err || tlast_err || keep_err;
    discard      = sof_miss_err || tlast_err;

    load      = 1'b0;
    load_pix  = '0;
    state_nxt = state;
    if (acc && discard) begin
      state_nxt = ST_SYNC;
    end else if (active) begin
      case (eff_state)
        ST_PH0: begin
          load      = 1'b1;
          load_pix  = in_stream_tdata[23:0];
          state_nxt = ST_PH1;
        end
        ST_PH1: begin
          load      = 1'b1;
          load_pix  = {in_stream_tdata[15:0], r8};
          state_nxt = ST_PH2;
        end
        ST_PH2: begin
          load      = 1'b1;
          load_pix  = {in_stream_tdata[7:0], r16};
          state_nxt = ST_EMIT3;
        end
        default: ;
      endcase
    end else if ((state == ST_EMIT3) && out_hs) begin
      load      = 1'b1;
      load_pix  = p3;
      state_nxt = ST_PH0;
    end

    load_beat.data = load_pix;
    load_beat.x    = eff_x;
    load_beat.y    = eff_y;
    load_beat.sof  = (eff_x == '0) && (eff_y == '0);
    load_beat.eol  = (eff_x == X_LAST);

    last_p3 = (state == ST_EMIT3) && out_hs && (nx == X_LAST) && (ny == Y_LAST);
  end

  // Sequencer state, residual bytes, position counters and statistics.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_SYNC;
      run       <= 1'b0;
      r8        <= '0;
      r16       <= '0;
      p3        <= '0;
      nx        <= '0;
      ny        <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      run       <= 1'b1;
      state     <= state_nxt;
      err_pulse <= any_err;
      if (any_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;

      // A frame start clears history of the previous frame.
      if (start) frame_err <= keep_err;
      else if (any_err) frame_err <= 1'b1;

      if (active && !discard) begin
        if (eff_state == ST_PH0) r8  <= in_stream_tdata[31:24];
        if (eff_state == ST_PH1) r16 <= in_stream_tdata[31:16];
        if (eff_state == ST_PH2) p3  <= in_stream_tdata[31:8];
      end

      if (load) begin
        if (eff_x == X_LAST) begin
          nx <= '0;
          ny <= (eff_y == Y_LAST) ? '0 : eff_y + 1'b1;
        end else begin
          nx <= eff_x + 1'b1;
          ny <= eff_y;
        end
      end

      if (last_p3 && !frame_err) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  pix_out_reg u_out (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .load_beat (load_beat),
    .ready     (pix_ready),
    .valid     (out_valid),
    .beat      (out_beat),
    .handshake (out_hs)
  );

  assign pix_valid = out_valid;
  assign pix_data  = out_beat.data;
  assign pix_sof   = out_beat.sof;
  assign pix_eol   = out_beat.eol;
  assign pix_x     = out_beat.x;
  assign pix_y     = out_beat.y;

endmodule
